// File: rtl/output_port_scheduler_if.sv
// rtl/output_port_scheduler_if.sv - request/grant/commit signals of one output port scheduler
interface output_port_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int SEL_W   = 2
);
   logic [NUM_REQ-1:0] req;
   logic               out_empty;
   logic [NUM_REQ-1:0] grant;
   logic [SEL_W-1:0]   sel;
   logic               load;
   logic [NUM_REQ-1:0] clear;
   logic               busy;
   logic               timeout;

   // Scheduler side
   modport master (
      input  req, out_empty,
      output grant, sel, load, clear, busy, timeout
   );

   // Input buffers / output controller side
   modport slave (
      output req, out_empty,
      input  grant, sel, load, clear, busy, timeout
   );
endinterface

// File: rtl/output_port_scheduler.sv
// rtl/output_port_scheduler.sv - round-robin scheduler for one router output port
// Optional grant-hold timeout is enabled by defining ARB_TIMEOUT_EN.
module output_port_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int SEL_W          = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                     clk,
   input logic                     reset,
   output_port_scheduler_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
   logic [SEL_W-1:0]   r_sel, w_sel_nxt;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
   logic [NUM_REQ-1:0] r_clear, w_clear_nxt;
   logic               r_load, w_load_nxt;
   logic [SEL_W-1:0]   w_cand [NUM_REQ];
   logic [SEL_W-1:0]   w_winner;
   logic               w_found;
   logic [SEL_W-1:0]   w_sel_inc;
`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]   r_wait, w_wait_nxt;
   logic               r_timeout, w_timeout_nxt;
`endif

   // Next pointer after the current owner, wrapping at NUM_REQ
   assign w_sel_inc = (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + SEL_W'(1);

   // Candidate index for each round-robin position, starting at r_ptr
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cand[i] = SEL_W'((int'(r_ptr) + i) % NUM_REQ);
      end
   end

   // First pending request in round-robin order
   always_comb begin
      w_winner = r_ptr;
      w_found  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && bus.req[w_cand[i]]) begin
            w_winner = w_cand[i];
            w_found  = 1'b1;
         end
      end
   end

   // Next-state and registered-output logic for IDLE -> GRANT -> COMMIT
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_sel_nxt   = r_sel;
      w_grant_nxt = r_grant;
      w_load_nxt  = 1'b0;
      w_clear_nxt = '0;
`ifdef ARB_TIMEOUT_EN
      w_timeout_nxt = 1'b0;
      w_wait_nxt    = bus.out_empty ? '0 : r_wait;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_GRANT;
               w_sel_nxt   = w_winner;
               w_grant_nxt = NUM_REQ'(1) << w_winner;
`ifdef ARB_TIMEOUT_EN
               w_wait_nxt  = '0;
`endif
            end
         end
         S_GRANT: begin
            // Withdrawal wins over a free output buffer; ptr keeps its place
            if (!bus.req[r_sel]) begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = '0;
            end else if (bus.out_empty) begin
               w_state_nxt = S_COMMIT;
               w_load_nxt  = 1'b1;
               w_clear_nxt = r_grant;
            end
`ifdef ARB_TIMEOUT_EN
            else if (r_wait == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Blocked owner gives up its turn
               w_state_nxt   = S_IDLE;
               w_grant_nxt   = '0;
               w_ptr_nxt     = w_sel_inc;
               w_timeout_nxt = 1'b1;
               w_wait_nxt    = '0;
            end else begin
               w_wait_nxt = r_wait + CNT_W'(1);
            end
`endif
         end
         S_COMMIT: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = w_sel_inc;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // State and output registers; reset aborts any grant or pulse in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_grant <= '0;
         r_clear <= '0;
         r_load  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_wait    <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel_nxt;
         r_grant <= w_grant_nxt;
         r_clear <= w_clear_nxt;
         r_load  <= w_load_nxt;
`ifdef ARB_TIMEOUT_EN
         r_wait    <= w_wait_nxt;
         r_timeout <= w_timeout_nxt;
`endif
      end
   end

   assign bus.grant = r_grant;
   assign bus.sel   = r_sel;
   assign bus.load  = r_load;
   assign bus.clear = r_clear;
   assign bus.busy  = (r_state != S_IDLE);
`ifdef ARB_TIMEOUT_EN
   assign bus.timeout = r_timeout;
`else
   // Grants wait indefinitely, so there is never an abort to report
   assign bus.timeout = 1'b0;
`endif
endmodule
